// File: rtl/riscv_pkg.sv
// Shared types and sizing for the barrel core and its block-RAM helpers.
package riscv_pkg;

  typedef enum logic {BRAM_CLEAR, BRAM_READY} bram_init_state_t;

  localparam int unsigned NUM_HARTS     = 4;
  localparam int unsigned XLEN          = 32;
  // One 32-entry architectural register file per hart, stacked in one array.
  localparam int unsigned RF_DEPTH      = NUM_HARTS * 32;
  localparam int unsigned RF_ADDR_WIDTH = $clog2(RF_DEPTH);
  localparam int unsigned RF_DATA_WIDTH = XLEN;

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sequencer: walks every address once with a zeroing write,
// then parks in READY until the next reset.
module bram_clear_seq
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr   = ADDR_WIDTH'(DEPTH - 1);
  localparam bram_init_state_t      ResetState = CLEAR_ON_RESET ? BRAM_CLEAR : BRAM_READY;

  bram_init_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      BRAM_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = BRAM_READY;
          cnt_d   = '0;
        end
      end
      BRAM_READY: ;
      default: state_d = ResetState;
    endcase
  end

  assign init_busy = (state_q == BRAM_CLEAR);
  assign clr_addr  = cnt_q;

endmodule

// File: rtl/bram_sdp_be_clr.sv
// Simple-dual-port block RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable collision policy and a post-reset zeroing sweep.
module bram_sdp_be_clr
  import riscv_pkg::*;
#(
  parameter int unsigned  DEPTH          = 512,
  parameter int unsigned  ADDR_WIDTH     = 9,
  parameter int unsigned  DATA_WIDTH     = 32,
  parameter int unsigned  BYTE_WIDTH     = 8,
  parameter int unsigned  READ_LATENCY   = 1,
  parameter bit           BYPASS         = 1'b1,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  parameter string        RAM_STYLE_ATTR = "block",
  localparam int unsigned NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DEPTH > (2 ** ADDR_WIDTH) ||
      (READ_LATENCY != 1 && READ_LATENCY != 2) || RAM_STYLE_ATTR == "") begin : g_bad_param
    $error("bram_sdp_be_clr: illegal parameter combination");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  bram_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic wr_in_range, rd_in_range, user_we, rd_fire, hit;

  assign wr_in_range = {1'b0, wr_addr} < DepthExt;
  assign rd_in_range = {1'b0, rd_addr} < DepthExt;
  assign user_we     = wr_en & ~init_busy & wr_in_range;
  assign rd_fire     = rd_en & ~init_busy;
  assign hit         = BYPASS & user_we & rd_fire & (rd_addr == wr_addr);

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [NUM_BYTES-1:0]  arr_be;

  always_comb begin
    arr_we   = user_we;
    arr_addr = wr_addr;
    arr_data = wr_data;
    arr_be   = wr_be;
    if (init_busy) begin
      arr_we   = clr_we;
      arr_addr = clr_addr;
      arr_data = '0;
      arr_be   = '1;
    end
  end

  (* ram_style = RAM_STYLE_ATTR *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;

  // No reset here so the array and its output register map onto a BRAM primitive.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (arr_be[i]) mem[arr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= arr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (rd_fire && rd_in_range) mem_q <= mem[rd_addr];
  end

  logic                  v1_q, zero_q, hit_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [NUM_BYTES-1:0]  wbe_q;

  // zero_q masks the uninitialised output register after reset and out-of-range reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      zero_q <= 1'b1;
      hit_q  <= 1'b0;
      wd_q   <= '0;
      wbe_q  <= '0;
    end else begin
      v1_q <= rd_fire;
      if (rd_fire) begin
        zero_q <= ~rd_in_range;
        hit_q  <= hit;
        wd_q   <= wr_data;
        wbe_q  <= wr_be;
      end
    end
  end

  logic [DATA_WIDTH-1:0] s1_word;

  always_comb begin
    s1_word = mem_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (hit_q && wbe_q[i]) s1_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wd_q[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    if (zero_q) s1_word = '0;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= s1_word;
      end
    end

    assign rd_valid = v2_q;
    assign rd_data  = d2_q;
  end else begin : g_lat1
    assign rd_valid = v1_q;
    assign rd_data  = s1_word;
  end

endmodule

// File: tb/tb_bram_sdp_be_clr.sv
// Directed bench: instance a (16 words, latency 1, write-first) and
// instance b (12 words of 16 addressable, latency 2, read-first).
module tb_bram_sdp_be_clr;

  logic clk, reset_n;

  logic        a_wr_en, a_rd_en, a_rd_valid, a_busy;
  logic [3:0]  a_wr_be, a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_wr_en, b_rd_en, b_rd_valid, b_busy;
  logic [3:0]  b_wr_be, b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int ca, cb, n;

  bram_sdp_be_clr #(
    .DEPTH        (16),
    .ADDR_WIDTH   (4),
    .READ_LATENCY (1),
    .BYPASS       (1'b1)
  ) u_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (a_wr_en),
    .wr_be     (a_wr_be),
    .wr_addr   (a_wr_addr),
    .wr_data   (a_wr_data),
    .rd_en     (a_rd_en),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .rd_valid  (a_rd_valid),
    .init_busy (a_busy)
  );

  bram_sdp_be_clr #(
    .DEPTH        (12),
    .ADDR_WIDTH   (4),
    .READ_LATENCY (2),
    .BYPASS       (1'b0)
  ) u_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (b_wr_en),
    .wr_be     (b_wr_be),
    .wr_addr   (b_wr_addr),
    .wr_data   (b_wr_data),
    .rd_en     (b_rd_en),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .rd_valid  (b_rd_valid),
    .init_busy (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = d; a_wr_be = be;
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = d; b_wr_be = be;
    step();
    b_wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_wr_be = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0;
    b_wr_en = 0; b_rd_en = 0; b_wr_be = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
    step();
    step();

    // Reset state
    chk("rst_a_data", a_rd_data, 32'h0);
    chk("rst_a_valid", 32'(a_rd_valid), 32'h0);
    chk("rst_a_busy", 32'(a_busy), 32'h1);
    chk("rst_b_data", b_rd_data, 32'h0);
    chk("rst_b_busy", 32'(b_busy), 32'h1);

    // Sweep length: busy cycles counted from reset release
    reset_n = 1'b1;
    ca = 0; cb = 0;
    for (int i = 0; i < 24; i++) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      step();
    end
    chk("sweep_len_a", 32'(ca), 32'd16);
    chk("sweep_len_b", 32'(cb), 32'd12);

    // Every address reads zero, valid one cycle after request
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 4'(i);
      step();
      chk($sformatf("clr_valid_%0d", i), 32'(a_rd_valid), 32'h1);
      chk($sformatf("clr_data_%0d", i), a_rd_data, 32'h0);
    end
    a_rd_en = 1'b0;
    step();
    chk("idle_valid_a", 32'(a_rd_valid), 32'h0);

    // Byte enables, including an all-zero enable that must not write
    a_write(4'd5, 32'hDEADBEEF, 4'b1111);
    a_write(4'd5, 32'h00001234, 4'b0011);
    a_write(4'd5, 32'hFFFFFFFF, 4'b0000);
    a_rd_en = 1'b1; a_rd_addr = 4'd5;
    step();
    chk("be_data", a_rd_data, 32'hDEAD1234);
    chk("be_valid", 32'(a_rd_valid), 32'h1);

    // Write-first collision
    a_rd_en = 1'b0;
    a_write(4'd7, 32'h11111111, 4'b1111);
    a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 32'hAABBCCDD; a_wr_be = 4'b0101;
    a_rd_en = 1'b1; a_rd_addr = 4'd7;
    step();
    a_wr_en = 1'b0;
    chk("coll_byp", a_rd_data, 32'h11BB11DD);
    chk("coll_byp_valid", 32'(a_rd_valid), 32'h1);
    step();
    a_rd_en = 1'b0;
    chk("coll_byp_after", a_rd_data, 32'h11BB11DD);
    a_write(4'd7, 32'h55555555, 4'b1111);
    chk("hold_a_data", a_rd_data, 32'h11BB11DD);
    chk("hold_a_valid", 32'(a_rd_valid), 32'h0);

    // Fill instance b
    b_write(4'd1, 32'h000000A1, 4'b1111);
    b_write(4'd2, 32'h000000B2, 4'b1111);
    b_write(4'd3, 32'h000000C3, 4'b1111);
    b_write(4'd7, 32'h11111111, 4'b1111);
    b_write(4'd11, 32'h0B0B0B0B, 4'b1111);
    b_write(4'd13, 32'hFFFFFFFF, 4'b1111);

    // Latency 2: reads in cycles 0,1,2
    b_rd_en = 1'b1; b_rd_addr = 4'd1;
    chk("lat_v0", 32'(b_rd_valid), 32'h0);
    step();
    b_rd_addr = 4'd2;
    chk("lat_v1", 32'(b_rd_valid), 32'h0);
    step();
    b_rd_addr = 4'd3;
    chk("lat_v2", 32'(b_rd_valid), 32'h1);
    chk("lat_d2", b_rd_data, 32'h000000A1);
    step();
    b_rd_en = 1'b0;
    chk("lat_v3", 32'(b_rd_valid), 32'h1);
    chk("lat_d3", b_rd_data, 32'h000000B2);
    step();
    chk("lat_v4", 32'(b_rd_valid), 32'h1);
    chk("lat_d4", b_rd_data, 32'h000000C3);
    step();
    chk("lat_v5", 32'(b_rd_valid), 32'h0);
    chk("lat_d5_hold", b_rd_data, 32'h000000C3);

    // Write after the read cycle is not forwarded into the pipeline
    b_rd_en = 1'b1; b_rd_addr = 4'd1;
    step();
    b_rd_en = 1'b0;
    b_wr_en = 1'b1; b_wr_addr = 4'd1; b_wr_data = 32'h99999999; b_wr_be = 4'b1111;
    step();
    b_wr_en = 1'b0;
    chk("snap_data", b_rd_data, 32'h000000A1);
    chk("snap_valid", 32'(b_rd_valid), 32'h1);

    // Read-first collision
    b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 32'hAABBCCDD; b_wr_be = 4'b0101;
    b_rd_en = 1'b1; b_rd_addr = 4'd7;
    step();
    b_wr_en = 1'b0;
    step();
    b_rd_en = 1'b0;
    chk("coll_rf", b_rd_data, 32'h11111111);
    step();
    chk("coll_rf_after", b_rd_data, 32'h11BB11DD);
    chk("coll_rf_valid", 32'(b_rd_valid), 32'h1);

    // Out-of-range: write to 13 dropped, read of 13 returns zero but valid
    b_rd_en = 1'b1; b_rd_addr = 4'd11;
    step();
    b_rd_addr = 4'd13;
    step();
    b_rd_en = 1'b0;
    chk("oor_addr11", b_rd_data, 32'h0B0B0B0B);
    step();
    chk("oor_data", b_rd_data, 32'h0);
    chk("oor_valid", 32'(b_rd_valid), 32'h1);

    // Reset mid-sweep with user traffic held active throughout
    reset_n = 1'b0;
    #1;
    chk("rst2_a_data", a_rd_data, 32'h0);
    chk("rst2_a_valid", 32'(a_rd_valid), 32'h0);
    chk("rst2_b_valid", 32'(b_rd_valid), 32'h0);
    step();
    reset_n = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 4'd14; a_wr_data = 32'h12345678; a_wr_be = 4'b1111;
    a_rd_en = 1'b1; a_rd_addr = 4'd5;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("sweep1_valid_%0d", i), 32'(a_rd_valid), 32'h0);
      chk($sformatf("sweep1_data_%0d", i), a_rd_data, 32'h0);
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n = 0;
    while (a_busy && n < 40) begin
      chk($sformatf("sweep2_valid_%0d", n), 32'(a_rd_valid), 32'h0);
      step();
      n++;
    end
    a_wr_en = 1'b0;
    a_rd_en = 1'b0;
    chk("sweep_len_restart", 32'(n), 32'd16);

    a_rd_en = 1'b1; a_rd_addr = 4'd14;
    step();
    chk("clr_wr_ignored", a_rd_data, 32'h0);
    chk("clr_rd_valid", 32'(a_rd_valid), 32'h1);
    a_rd_addr = 4'd5;
    step();
    chk("recleared_5", a_rd_data, 32'h0);
    a_rd_addr = 4'd7;
    step();
    chk("recleared_7", a_rd_data, 32'h0);
    a_rd_en = 1'b0;

    b_rd_en = 1'b1; b_rd_addr = 4'd11;
    step();
    b_rd_en = 1'b0;
    step();
    chk("recleared_b11", b_rd_data, 32'h0);
    chk("recleared_b11_valid", 32'(b_rd_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_sdp_be_clr.md
Name: bram_sdp_be_clr

Overview:
- Parametrised simple-dual-port block RAM: one write port, one read port, single clock.
- Adds byte-lane write enables, selectable read latency (1 or 2), configurable read/write collision policy, and a post-reset clear sweep that zeroes the array.
- Used for the per-hart register file and scratch buffers of the barrel core, where x0 and all state must read zero after reset without relying on bitstream initialisation.

Parameters:
- DEPTH, 512: number of words.
- ADDR_WIDTH, 9: address width; DEPTH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- BYTE_WIDTH, 8: lane width; DATA_WIDTH must be a multiple of it.
- NUM_BYTES, DATA_WIDTH/BYTE_WIDTH: derived localparam, not overridable.
- READ_LATENCY, 1: 1 = array output register only; 2 = additional output register.
- BYPASS, 1: 1 = write-first on same-address collision; 0 = read-first.
- CLEAR_ON_RESET, 1: 1 = run zeroing sweep after reset; 0 = READY immediately.
- RAM_STYLE_ATTR, "block": synthesis ram_style attribute on the array.

Ports:
- clk, input, 1: single clock.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: write request.
- wr_be, input, NUM_BYTES: byte-lane enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr, input, ADDR_WIDTH: write address.
- wr_data, input, DATA_WIDTH: write data.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_WIDTH: read address.
- rd_data, output, DATA_WIDTH: read data.
- rd_valid, output, 1: rd_data carries the result of a read issued READ_LATENCY cycles earlier.
- init_busy, output, 1: clear sweep in progress; requests are ignored while high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: rd_data = 0, rd_valid = 0, init_busy = CLEAR_ON_RESET, clear counter = 0, pipeline registers = 0.
- The array itself has no reset; its contents are defined only by the clear sweep or by writes.
- FSM states:
  - CLEAR: each cycle writes all-zero to counter address with all lanes enabled; counter increments.
  - CLEAR -> READY after the write to DEPTH-1. init_busy is high for exactly DEPTH cycles after reset release and falls on the next edge.
  - READY: normal operation; terminal until reset.
- Reset asserted mid-sweep: sweep restarts at address 0 after release.
- While CLEAR: wr_en and rd_en are ignored, no array write from the user port, rd_valid stays 0, rd_data holds 0.
- Write (READY): on wr_en, each lane with wr_be[i]=1 is updated at the clock edge; other lanes keep their value.
  - wr_be = 0 is a no-op.
  - Data is visible to a read issued in the next cycle.
- Read latency:
  - READ_LATENCY=1: rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1.
  - READ_LATENCY=2: result appears in cycle N+2.
  - rd_valid is rd_en delayed by READ_LATENCY.
  - rd_data holds its last value when no read completes; it is not zeroed.
- Same-cycle collision (rd_en & wr_en & rd_addr==wr_addr):
  - BYPASS=1: returned word = wr_data on lanes with wr_be=1, old array content on others. Merge is done in the output stage from the registered wr_data/wr_be/hit flag.
  - BYPASS=0: returns the pre-write content.
- A write issued after the read cycle, while the read is still in the output pipeline (READ_LATENCY=2), is not forwarded; the result is a snapshot at read issue.
- Out-of-range address (>= DEPTH, when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Back-to-back reads and writes every cycle are fully supported; no stalls and no backpressure.

Decomposition:
- Package riscv_pkg:
  - typedef enum logic {BRAM_CLEAR, BRAM_READY} bram_init_state_t;
  - default localparams for register-file depth and width (e.g. RF_DEPTH, RF_ADDR_WIDTH) shared with the core.
- Sub-module bram_clear_seq:
  - Owns the FSM and address counter.
  - Outputs init_busy, clr_we, clr_addr; parametrised by DEPTH, ADDR_WIDTH, CLEAR_ON_RESET.
- The top block muxes the clear port against the user write port and owns the array, byte merge and output pipeline.

Test Plan:
- Clear sweep: DEPTH=16, release reset_n -> init_busy high exactly 16 cycles. Read of every address afterwards returns 0x00000000 with rd_valid one cycle later.
- Byte enables: write 0xDEADBEEF to addr 5 with be=4'b1111, then 0x00001234 with be=4'b0011; read addr 5 -> 0xDEAD1234.
- Collision, BYPASS=1: addr 7 holds 0x11111111; same cycle write 0xAABBCCDD be=4'b0101 and read addr 7 -> 0x11BB11DD. With BYPASS=0 -> 0x11111111.
- Latency: READ_LATENCY=2, reads issued on cycles 0,1,2 to addrs 1,2,3 -> data on cycles 2,3,4. rd_valid pattern 0,0,1,1,1,0; rd_data holds after.
- Reset mid-sweep: DEPTH=16, assert reset_n low at sweep cycle 9, release -> init_busy high 16 full cycles again, rd_data/rd_valid 0 during reset. User writes during CLEAR are not stored.
- Out-of-range: DEPTH=12, ADDR_WIDTH=4: write 0xFFFFFFFF to addr 13, read addr 13 -> 0 with rd_valid=1. Addr 11 unaffected.
